// File: rtl/ultrassom_controlador.sv
// HC-SR04 ultrasonic sequencer: trigger, echo timing, cm conversion and
// N-sample confirmed 10-20 cm window flag driving the barrier LED.
//
// state     | meaning
// IDLE      | no measurement running, waits for enable
// TRIG      | trig held high for TRIG_CYCLES
// WAIT_ECHO | waits for echo_s rise, bounded by WAIT_TIMEOUT
// MEASURE   | counts echo_s high cycles into cm
// DONE      | publishes the distance (one cycle)
// HOLDOFF   | pads the cycle out to PERIOD_CYCLES between triggers
module ultrassom_controlador #(
    parameter int TRIG_CYCLES   = 500,
    parameter int CM_CYCLES     = 2900,
    parameter int WAIT_TIMEOUT  = 1_500_000,
    parameter int MAX_CM        = 200,
    parameter int PERIOD_CYCLES = 3_000_000,
    parameter int MIN_CM        = 10,
    parameter int MAX_LIM_CM    = 20,
    parameter int CONFIRM       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       echo,
    output logic       trig,
    output logic [7:0] distancia_cm,
    output logic       medida_valida,
    output logic       timeout,
    output logic       ocupado,
    output logic       dentro_limite,
    output logic       led
);

    localparam int TMR_W = $clog2((WAIT_TIMEOUT > TRIG_CYCLES) ? WAIT_TIMEOUT : TRIG_CYCLES) + 1;
    localparam int PER_W = $clog2(PERIOD_CYCLES) + 1;
    localparam int SUB_W = $clog2(CM_CYCLES) + 1;
    localparam int AGR_W = $clog2(CONFIRM) + 1;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF} state_t;

    state_t           state;
    logic             echo_m;
    logic             echo_s;
    logic [TMR_W-1:0] tmr;
    logic [PER_W-1:0] per_cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic [7:0]       cm_cnt;
    logic [AGR_W-1:0] agree_cnt;
    logic             amostra;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            tmr           <= '0;
            per_cnt       <= '0;
            sub_cnt       <= '0;
            cm_cnt        <= '0;
            trig          <= 1'b0;
            distancia_cm  <= '0;
            medida_valida <= 1'b0;
            timeout       <= 1'b0;
            ocupado       <= 1'b0;
        end else begin
            medida_valida <= 1'b0;
            timeout       <= 1'b0;
            if (per_cnt != '1)
                per_cnt <= per_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= TRIG;
                        trig    <= 1'b1;
                        ocupado <= 1'b1;
                        tmr     <= TMR_W'(TRIG_CYCLES - 1);
                        per_cnt <= '0;
                    end
                end
                TRIG: begin
                    if (tmr == '0) begin
                        trig  <= 1'b0;
                        state <= WAIT_ECHO;
                        tmr   <= TMR_W'(WAIT_TIMEOUT - 1);
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    // the rising cycle itself is the first counted high cycle
                    if (echo_s) begin
                        state   <= MEASURE;
                        sub_cnt <= SUB_W'(1);
                        cm_cnt  <= '0;
                    end else if (tmr == '0) begin
                        timeout <= 1'b1;
                        state   <= HOLDOFF;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        state         <= DONE;
                        distancia_cm  <= cm_cnt;
                        medida_valida <= 1'b1;
                    end else if (sub_cnt == SUB_W'(CM_CYCLES - 1)) begin
                        sub_cnt <= '0;
                        if (cm_cnt != 8'hFF)
                            cm_cnt <= cm_cnt + 1'b1;
                        if (cm_cnt == 8'(MAX_CM - 1)) begin
                            timeout <= 1'b1;
                            state   <= HOLDOFF;
                        end
                    end else begin
                        sub_cnt <= sub_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (per_cnt >= PER_W'(PERIOD_CYCLES - 1)) begin
                        if (enable) begin
                            state   <= TRIG;
                            trig    <= 1'b1;
                            tmr     <= TMR_W'(TRIG_CYCLES - 1);
                            per_cnt <= '0;
                        end else begin
                            state   <= IDLE;
                            ocupado <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    trig    <= 1'b0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    // distancia_cm is already updated while medida_valida is high; a timeout is an out sample
    assign amostra = medida_valida &&
                     (distancia_cm >= 8'(MIN_CM)) && (distancia_cm <= 8'(MAX_LIM_CM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            agree_cnt     <= '0;
            dentro_limite <= 1'b0;
        end else if (medida_valida || timeout) begin
            if (amostra == dentro_limite) begin
                agree_cnt <= '0;
            end else if (agree_cnt == AGR_W'(CONFIRM - 1)) begin
                agree_cnt     <= '0;
                dentro_limite <= ~dentro_limite;
            end else begin
                agree_cnt <= agree_cnt + 1'b1;
            end
        end
    end

    assign led = dentro_limite;

endmodule

// File: tb/tb_ultrassom_controlador.sv
// Directed bench for ultrassom_controlador with shortened timing parameters.
module tb_ultrassom_controlador;

    localparam int CM = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       echo;
    logic       trig;
    logic [7:0] distancia_cm;
    logic       medida_valida;
    logic       timeout;
    logic       ocupado;
    logic       dentro_limite;
    logic       led;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         exp_dl = 0;
    int         exp_cnt = 0;
    logic [7:0] last_d = 8'd0;
    int         last_rise = 0;
    int         prev_rise = 0;
    int         n;

    ultrassom_controlador #(
        .TRIG_CYCLES(4), .CM_CYCLES(CM), .WAIT_TIMEOUT(200), .MAX_CM(100),
        .PERIOD_CYCLES(2000), .CONFIRM(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
        .distancia_cm(distancia_cm), .medida_valida(medida_valida),
        .timeout(timeout), .ocupado(ocupado), .dentro_limite(dentro_limite),
        .led(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // sel 0: trig high, 1: trig low, 2: any strobe; n = negedges waited, -1 if bound expired
    task automatic wait_for(input int sel, input int bound, output int nw);
        nw = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((sel == 0 && trig === 1'b1) || (sel == 1 && trig === 1'b0) ||
                (sel == 2 && (medida_valida === 1'b1 || timeout === 1'b1))) begin
                nw = i + 1;
                break;
            end
        end
    endtask

    task automatic model_sample(input int s);
        if (s == exp_dl) begin
            exp_cnt = 0;
        end else begin
            exp_cnt++;
            if (exp_cnt == 2) begin
                exp_dl  = 1 - exp_dl;
                exp_cnt = 0;
            end
        end
    endtask

    task automatic check_filter(input string tag);
        @(negedge clk);
        chk({tag, " strobe_one_cycle"}, 32'(medida_valida | timeout), 32'(0));
        chk({tag, " dentro_limite"}, 32'(dentro_limite), 32'(exp_dl));
        chk({tag, " led"}, 32'(led), 32'(exp_dl));
    endtask

    // one full measurement cycle with an echo pulse of 'width' cycles (0 = no echo)
    task automatic measure(input int width, input string tag);
        int   nw;
        int   d;
        logic valid;
        d     = width / CM;
        valid = (width > 0) && (d < 100);
        wait_for(0, 2100, nw);
        chk({tag, " trig_rise_seen"}, 32'(nw > 0), 32'(1));
        prev_rise = last_rise;
        last_rise = cyc;
        chk({tag, " ocupado"}, 32'(ocupado), 32'(1));
        wait_for(1, 10, nw);
        chk({tag, " trig_high_cycles"}, nw, 4);
        if (width > 0) begin
            echo = 1'b1;
            repeat (width) @(negedge clk);
            echo = 1'b0;
            wait_for(2, 300, nw);
            chk({tag, " strobe_latency"}, nw, 3);
        end else begin
            wait_for(2, 300, nw);
            chk({tag, " timeout_latency"}, nw, 200);
        end
        chk({tag, " medida_valida"}, 32'(medida_valida), 32'(valid));
        chk({tag, " timeout"}, 32'(timeout), 32'(!valid));
        if (valid) last_d = 8'(d);
        chk({tag, " distancia_cm"}, 32'(distancia_cm), 32'(last_d));
        model_sample((valid && d >= 10 && d <= 20) ? 1 : 0);
        check_filter(tag);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        echo   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset trig", 32'(trig), 32'(0));
        chk("reset distancia_cm", 32'(distancia_cm), 32'(0));
        chk("reset medida_valida", 32'(medida_valida), 32'(0));
        chk("reset timeout", 32'(timeout), 32'(0));
        chk("reset ocupado", 32'(ocupado), 32'(0));
        chk("reset dentro_limite", 32'(dentro_limite), 32'(0));
        chk("reset led", 32'(led), 32'(0));
        rst    = 1'b0;
        enable = 1'b1;

        measure(150, "d15_a");
        measure(150, "d15_b");
        chk("trigger_period", last_rise - prev_rise, 2000);
        measure(150, "d15_c");

        measure(205, "d20_a");
        measure(205, "d20_b");
        measure(100, "d10_a");
        measure(100, "d10_b");
        measure(99,  "d9_a");
        measure(99,  "d9_b");
        measure(215, "d21_a");
        measure(215, "d21_b");

        measure(150, "rein_a");
        measure(150, "rein_b");
        measure(0, "noecho_a");
        measure(0, "noecho_b");

        // echo stuck high from before WAIT_ECHO is entered
        wait_for(0, 2100, n);
        chk("stuck trig_rise_seen", 32'(n > 0), 32'(1));
        echo = 1'b1;
        wait_for(1, 10, n);
        chk("stuck trig_high_cycles", n, 4);
        wait_for(2, 1100, n);
        chk("stuck timeout_latency", n, 1000);
        chk("stuck timeout", 32'(timeout), 32'(1));
        chk("stuck medida_valida", 32'(medida_valida), 32'(0));
        chk("stuck distancia_cm", 32'(distancia_cm), 32'(last_d));
        model_sample(0);
        check_filter("stuck");
        repeat (499) @(negedge clk);
        echo = 1'b0;

        // reset in the middle of MEASURE
        wait_for(0, 2100, n);
        chk("rstmid trig_rise_seen", 32'(n > 0), 32'(1));
        wait_for(1, 10, n);
        echo = 1'b1;
        repeat (50) @(negedge clk);
        chk("rstmid ocupado_before", 32'(ocupado), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("rstmid trig", 32'(trig), 32'(0));
        chk("rstmid distancia_cm", 32'(distancia_cm), 32'(0));
        chk("rstmid medida_valida", 32'(medida_valida), 32'(0));
        chk("rstmid timeout", 32'(timeout), 32'(0));
        chk("rstmid ocupado", 32'(ocupado), 32'(0));
        chk("rstmid dentro_limite", 32'(dentro_limite), 32'(0));
        chk("rstmid led", 32'(led), 32'(0));
        @(negedge clk);
        echo = 1'b0;
        exp_dl  = 0;
        exp_cnt = 0;
        last_d  = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        measure(250, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ultrassom_controlador.md
Name: ultrassom_controlador

Overview:
Controls an HC-SR04-style ultrasonic sensor and feeds the 10–20 cm barrier datapath. Each measurement cycle issues a trigger pulse, times the echo, converts the echo width to whole centimetres and applies the min/max window with N-sample confirmation. It drives `led` and `dentro_limite` directly and publishes `distancia_cm` with a valid strobe.

Parameters:
- TRIG_CYCLES, 500: trigger high time in clk cycles (10 µs @ 50 MHz).
- CM_CYCLES, 2900: echo-high clk cycles per centimetre (58 µs @ 50 MHz).
- WAIT_TIMEOUT, 1_500_000: maximum cycles from trigger fall to echo rise.
- MAX_CM, 200: echo length, in cm, at which the measurement aborts as a timeout.
- PERIOD_CYCLES, 3_000_000: minimum spacing between trigger rising edges.
- MIN_CM, 10: lower window limit, inclusive.
- MAX_LIM_CM, 20: upper window limit, inclusive.
- CONFIRM, 3: number of consecutive agreeing samples required to change `dentro_limite`.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  when 1, measurements repeat automatically.
- echo  in  1  sensor echo; asynchronous to clk.
- trig  out  1  trigger pulse to the sensor.
- distancia_cm  out  8  last valid distance in cm.
- medida_valida  out  1  one-cycle strobe when `distancia_cm` updates.
- timeout  out  1  one-cycle strobe when a measurement fails.
- ocupado  out  1  high in every state except IDLE.
- dentro_limite  out  1  confirmed in-window flag.
- led  out  1  equals `dentro_limite`.

Behaviour:
- Reset (async, rst=1): state IDLE; all counters 0; all outputs 0 (`trig`, `distancia_cm`, `medida_valida`, `timeout`, `ocupado`, `dentro_limite`, `led`).
- Reset applied mid-measurement aborts immediately and `trig` drops in the same cycle.
- Echo input: passes through a 2-flop synchroniser to produce `echo_s`. All decisions use `echo_s`; the synchroniser adds 2 cycles of latency but preserves pulse width.
- Period counter: cleared on entry to TRIG, then increments every cycle, saturating.
- State machine:
  - IDLE: if `enable`=1, go to TRIG.
  - TRIG: `trig`=1 for exactly TRIG_CYCLES cycles, then go to WAIT_ECHO.
  - WAIT_ECHO: when `echo_s`=1, go to MEASURE; that cycle counts as the first high cycle. If WAIT_TIMEOUT cycles pass with no rise, pulse `timeout` and go to HOLDOFF.
  - MEASURE: a sub-counter increments on each `echo_s`=1 cycle. When it reaches CM_CYCLES it wraps to 0 and the cm counter increments. On `echo_s` 1→0, go to DONE. If the cm counter reaches MAX_CM, pulse `timeout` and go to HOLDOFF.
  - DONE (1 cycle): `distancia_cm` ← cm counter; `medida_valida`=1; window filter updates; go to HOLDOFF.
  - HOLDOFF: wait until period counter ≥ PERIOD_CYCLES-1. Then go to TRIG if `enable`=1, otherwise IDLE.
- Distance arithmetic: N high cycles of `echo_s` gives `distancia_cm` = floor(N / CM_CYCLES). The cm counter is 8 bits and saturates at 255, so no wrap.
- Enable: dropping `enable` mid-measurement does not abort; the cycle completes and then returns to IDLE.
- Window sample: in = (MIN_CM ≤ d ≤ MAX_LIM_CM). A timeout counts as an out-of-window sample and leaves `distancia_cm` unchanged.
- Confirmation filter:
  - A sample equal to current `dentro_limite` clears the agreement counter.
  - A sample differing from current `dentro_limite` increments the counter.
  - When the counter reaches CONFIRM, `dentro_limite` toggles and the counter clears.
  - `dentro_limite` updates registered, in the cycle after the DONE/timeout strobe.
- `led` = `dentro_limite` at all times.
- Echo already high when WAIT_ECHO is entered (stuck sensor): MEASURE starts immediately. The resulting value is still bounded by the MAX_CM timeout.

Test Plan (TRIG_CYCLES=4, CM_CYCLES=10, WAIT_TIMEOUT=200, MAX_CM=100, PERIOD_CYCLES=2000, CONFIRM=2; defaults otherwise):
- Reset then `enable`=1 → `trig` high exactly 4 cycles; `ocupado`=1. Next `trig` rising edge comes exactly 2000 cycles after the first.
- Echo high 150 cycles, repeated → `distancia_cm`=15 with one-cycle `medida_valida` each time. `dentro_limite`/`led` rise only after the 2nd sample.
- Boundaries: echo widths 205, 100, 99, 215 → `distancia_cm` 20 (in), 10 (in), 9 (out), 21 (out). Drive each width twice to observe `led` settle.
- Echo never rises → `timeout` pulses 200 cycles after `trig` falls. Two such timeouts while in-window → `led` 1→0; `distancia_cm` unchanged.
- Echo held high 1500 cycles → `timeout` when the cm counter reaches 100; no `medida_valida`.
- rst asserted mid-MEASURE → all outputs 0 asynchronously. After release with `enable`=1, a fresh trigger follows and a 250-cycle echo gives `distancia_cm`=25.
